// File: rtl/fighter_action_sequencer.sv
// fighter_action_sequencer
//   Per-player action scheduler. It turns debounced button levels into timed
//   action phases: attack startup/active/recover, parry and hit-stun. Every
//   phase counter advances only on frame_tick. Movement is gated while the
//   fighter is busy. All outputs are registered and decoded from the
//   next-state, so they show a new phase in the cycle right after the edge
//   that enters it.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   frame_tick     one-cycle pulse per video frame
//   left/right/up/down  debounced direction levels
//   attack, parry  debounced button levels (edge-detected here)
//   hit_stun       one-cycle pulse: this fighter was hit
//   move_left/move_right/jump/crouch  movement commands, at most one high
//   attack_active  hitbox live (ACTIVE)
//   parry_active   parry window open (PARRY)
//   busy           phase is not IDLE
//   phase          IDLE=0 STARTUP=1 ACTIVE=2 RECOVER=3 PARRY=4 STUN=5
module fighter_action_sequencer #(
  parameter int unsigned STARTUP_FRAMES = 4,
  parameter int unsigned ACTIVE_FRAMES  = 6,
  parameter int unsigned RECOVER_FRAMES = 10,
  parameter int unsigned PARRY_FRAMES   = 8,
  parameter int unsigned STUN_FRAMES    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       attack,
  input  logic       parry,
  input  logic       hit_stun,
  output logic       move_left,
  output logic       move_right,
  output logic       jump,
  output logic       crouch,
  output logic       attack_active,
  output logic       parry_active,
  output logic       busy,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STARTUP = 3'd1,
    S_ACTIVE  = 3'd2,
    S_RECOVER = 3'd3,
    S_PARRY   = 3'd4,
    S_STUN    = 3'd5
  } state_t;

  localparam logic [7:0] LP_STARTUP = 8'(STARTUP_FRAMES);
  localparam logic [7:0] LP_ACTIVE  = 8'(ACTIVE_FRAMES);
  localparam logic [7:0] LP_RECOVER = 8'(RECOVER_FRAMES);
  localparam logic [7:0] LP_PARRY   = 8'(PARRY_FRAMES);
  localparam logic [7:0] LP_STUN    = 8'(STUN_FRAMES);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic       r_buf;
  logic       w_buf_next;
  logic       r_attack_q;
  logic       r_parry_q;

  logic       w_atk_press;
  logic       w_par_press;
  logic       w_expire;
  logic [3:0] w_move;

  assign w_atk_press = attack & ~r_attack_q;
  assign w_par_press = parry & ~r_parry_q;
  // A phase ends on the K-th tick after entry: the tick that finds cnt==1.
  assign w_expire    = frame_tick & (r_cnt == 8'd1);

  // State, counter and attack buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_buf      <= 1'b0;
      r_attack_q <= 1'b0;
      r_parry_q  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_buf      <= w_buf_next;
      r_attack_q <= attack;
      r_parry_q  <= parry;
    end
  end

  // Next-state, counter and buffer logic in the stated priority order
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_buf_next = r_buf;
    if (frame_tick && (r_cnt != '0)) begin
      w_cnt_next = r_cnt - 8'd1;
    end

    if (hit_stun) begin
      w_next     = S_STUN;
      w_cnt_next = LP_STUN;
      w_buf_next = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_par_press) begin
            w_next     = S_PARRY;
            w_cnt_next = LP_PARRY;
          end else if (w_atk_press || r_buf) begin
            w_next     = S_STARTUP;
            w_cnt_next = LP_STARTUP;
            w_buf_next = 1'b0;
          end
        end
        S_STARTUP: begin
          if (w_expire) begin
            w_next     = S_ACTIVE;
            w_cnt_next = LP_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (w_expire) begin
            w_next     = S_RECOVER;
            w_cnt_next = LP_RECOVER;
          end
        end
        S_RECOVER: begin
          // A buffered (or same-cycle) attack skips the IDLE state entirely
          // so no IDLE cycle appears on the registered outputs.
          if (w_expire) begin
            if (r_buf || w_atk_press) begin
              w_next     = S_STARTUP;
              w_cnt_next = LP_STARTUP;
              w_buf_next = 1'b0;
            end else begin
              w_next = S_IDLE;
            end
          end else if (w_atk_press) begin
            w_buf_next = 1'b1;
          end
        end
        S_PARRY, S_STUN: begin
          if (w_expire) begin
            w_next = S_IDLE;
          end
        end
        default: begin
          w_next     = S_IDLE;
          w_cnt_next = '0;
          w_buf_next = 1'b0;
        end
      endcase
    end
  end

  // Movement: fixed priority left > right > up > down, only when idle next
  always_comb begin
    w_move = '0;
    if (w_next == S_IDLE) begin
      if (left) begin
        w_move = 4'b1000;
      end else if (right) begin
        w_move = 4'b0100;
      end else if (up) begin
        w_move = 4'b0010;
      end else if (down) begin
        w_move = 4'b0001;
      end
    end
  end

  // Registered outputs decoded from the next-state
  always_ff @(posedge clk) begin
    if (rst) begin
      move_left     <= 1'b0;
      move_right    <= 1'b0;
      jump          <= 1'b0;
      crouch        <= 1'b0;
      attack_active <= 1'b0;
      parry_active  <= 1'b0;
      busy          <= 1'b0;
      phase         <= '0;
    end else begin
      move_left     <= w_move[3];
      move_right    <= w_move[2];
      jump          <= w_move[1];
      crouch        <= w_move[0];
      attack_active <= (w_next == S_ACTIVE);
      parry_active  <= (w_next == S_PARRY);
      busy          <= (w_next != S_IDLE);
      phase         <= w_next;
    end
  end

endmodule

// File: tb/tb_fighter_action_sequencer.sv
module tb_fighter_action_sequencer;

  localparam int ST = 4;
  localparam int AC = 6;
  localparam int RC = 10;
  localparam int PR = 8;
  localparam int SN = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
  logic attack = 1'b0, parry = 1'b0, hit_stun = 1'b0;
  logic move_left, move_right, jump, crouch;
  logic attack_active, parry_active, busy;
  logic [2:0] phase;

  fighter_action_sequencer #(
    .STARTUP_FRAMES(ST),
    .ACTIVE_FRAMES (AC),
    .RECOVER_FRAMES(RC),
    .PARRY_FRAMES  (PR),
    .STUN_FRAMES   (SN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .left         (left),
    .right        (right),
    .up           (up),
    .down         (down),
    .attack       (attack),
    .parry        (parry),
    .hit_stun     (hit_stun),
    .move_left    (move_left),
    .move_right   (move_right),
    .jump         (jump),
    .crouch       (crouch),
    .attack_active(attack_active),
    .parry_active (parry_active),
    .busy         (busy),
    .phase        (phase)
  );

  always #5 clk = ~clk;

  // Expected output vector: {ml, mr, jump, crouch, atk_act, par_act, busy, phase}
  logic [9:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tick_period = 10;   // 0 = frame_tick driven by the caller

  // Reference model: the fighter's action as a named phase plus ticks left
  int  m_ph = 0;
  int  m_left = 0;
  bit  m_buf = 0;
  bit  m_aq = 0;
  bit  m_pq = 0;

  task automatic model_and_push();
    bit ap, pp;
    logic [9:0] e;
    if (rst) begin
      m_ph = 0; m_left = 0; m_buf = 0; m_aq = 0; m_pq = 0;
      e = '0;
    end else begin
      ap = attack && !m_aq;
      pp = parry && !m_pq;
      if (hit_stun) begin
        m_ph = 5; m_left = SN; m_buf = 0;
      end else if (m_ph == 0) begin
        if (pp) begin
          m_ph = 4; m_left = PR;
        end else if (ap || m_buf) begin
          m_ph = 1; m_left = ST; m_buf = 0;
        end
      end else begin
        if (m_ph == 3 && ap) m_buf = 1;
        if (frame_tick) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            case (m_ph)
              1: begin m_ph = 2; m_left = AC; end
              2: begin m_ph = 3; m_left = RC; end
              3: begin
                if (m_buf) begin m_ph = 1; m_left = ST; m_buf = 0; end
                else m_ph = 0;
              end
              default: m_ph = 0;
            endcase
          end
        end
      end
      m_aq = attack;
      m_pq = parry;
      e = '0;
      if (m_ph == 0) begin
        if (left)       e[9] = 1'b1;
        else if (right) e[8] = 1'b1;
        else if (up)    e[7] = 1'b1;
        else if (down)  e[6] = 1'b1;
      end
      e[5]   = (m_ph == 2);
      e[4]   = (m_ph == 4);
      e[3]   = (m_ph != 0);
      e[2:0] = 3'(m_ph);
    end
    exp_q.push_back(e);
  endtask

  // One clock cycle: inputs are already applied at a falling edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      if (tick_period != 0) frame_tick = ((cyc % tick_period) == 0);
      model_and_push();
      @(negedge clk);
      cyc++;
      hit_stun = 1'b0;
    end
  endtask

  task automatic ticks(input int k);
    step(k * tick_period);
  endtask

  // Monitor: compare each registered output sample against the scoreboard
  initial begin
    logic [9:0] got, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {move_left, move_right, jump, crouch, attack_active,
               parry_active, busy, phase};
        n_tests++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs @cycle %0d: got {mv=%b aa=%b pa=%b busy=%b ph=%0d} expected {mv=%b aa=%b pa=%b busy=%b ph=%0d}",
                   cyc, got[9:6], got[5], got[4], got[3], got[2:0],
                   e[9:6], e[5], e[4], e[3], e[2:0]);
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    // Reset
    rst = 1'b1; step(3);
    rst = 1'b0;
    // Movement priority while idle
    right = 1'b1; step(5);
    left  = 1'b1; step(5);
    left = 1'b0; right = 1'b0; up = 1'b1; down = 1'b1; step(3);
    up = 1'b0; step(3);
    down = 1'b0; right = 1'b1;
    // Attack press with ticks every 10 cycles, direction still held
    attack = 1'b1; step(3); ticks(6);
    attack = 1'b0; step(2);
    attack = 1'b1; step(2);            // press during ACTIVE: discarded
    attack = 1'b0; ticks(8);
    attack = 1'b1; step(2);            // press mid-RECOVER: buffered
    attack = 1'b0; ticks(45);
    // Attack and parry together in IDLE, parry then held for 30 ticks
    right = 1'b0;
    attack = 1'b1; parry = 1'b1; ticks(30);
    attack = 1'b0; parry = 1'b0; ticks(2);
    // Hit during ACTIVE, then second hit 10 ticks later
    attack = 1'b1; step(2); attack = 1'b0; ticks(5);
    hit_stun = 1'b1; step(1); ticks(10);
    hit_stun = 1'b1; step(1); ticks(22);
    // Reset during STUN with 7 ticks left, attack held through it
    hit_stun = 1'b1; step(1); ticks(13);
    attack = 1'b1; step(3);
    rst = 1'b1; step(1); rst = 1'b0;
    ticks(45);
    attack = 1'b0;
    // Randomized phase
    tick_period = 0;
    for (int i = 0; i < 20000; i++) begin
      frame_tick = ($urandom_range(3) == 0);
      if ($urandom_range(5) == 0)  attack = ~attack;
      if ($urandom_range(19) == 0) parry  = ~parry;
      if ($urandom_range(7) == 0)  left   = ~left;
      if ($urandom_range(7) == 0)  right  = ~right;
      if ($urandom_range(7) == 0)  up     = ~up;
      if ($urandom_range(7) == 0)  down   = ~down;
      hit_stun = ($urandom_range(149) == 0);
      rst      = ($urandom_range(1499) == 0);
      step(1);
    end
    rst = 1'b0;
    @(posedge clk); #2;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
